// File: rtl/openddr_cmd_arbiter_if.sv
// openddr_cmd_arbiter_if: write/read request streams and the issued command stream of the arbiter
interface openddr_cmd_arbiter_if #(
  parameter int ADDR_WIDTH = 40,
  parameter int ID_WIDTH   = 12
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ID_WIDTH-1:0]   wr_id;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_len;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ID_WIDTH-1:0]   rd_id;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            rd_len;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ID_WIDTH-1:0]   cmd_id;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_len;
  modport master (
    output wr_valid, wr_id, wr_addr, wr_len, rd_valid, rd_id, rd_addr, rd_len, cmd_ready,
    input  wr_ready, rd_ready, cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_len
  );
  modport slave (
    input  wr_valid, wr_id, wr_addr, wr_len, rd_valid, rd_id, rd_addr, rd_len, cmd_ready,
    output wr_ready, rd_ready, cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_len
  );
endinterface

// File: rtl/openddr_cmd_arbiter.sv
// openddr_cmd_arbiter: read/write command arbiter with run limiting and turnaround bubbles
module openddr_cmd_arbiter #(
  parameter int ADDR_WIDTH = 40,
  parameter int ID_WIDTH   = 12,
  parameter int RUN_LIMIT  = 8,
  parameter int T_RTW      = 2,
  parameter int T_WTR      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  openddr_cmd_arbiter_if.slave bus,
  output logic                 turn_active
);
  localparam int RW   = $clog2(RUN_LIMIT + 1);
  localparam int TMAX = T_RTW > T_WTR ? T_RTW : T_WTR;
  localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam logic [RW-1:0] RL     = RW'(RUN_LIMIT);
  localparam logic [TW-1:0] RTW_M1 = TW'(T_RTW - 1);
  localparam logic [TW-1:0] WTR_M1 = TW'(T_WTR - 1);
  typedef enum logic {RUN, TURN} state_t;
  state_t                state, state_nx;
  logic                  last_dir, last_dir_nx, tgt_dir, tgt_dir_nx;
  logic [RW-1:0]         run_cnt, run_cnt_nx;
  logic [TW-1:0]         turn_cnt, turn_cnt_nx;
  logic                  vld_last, vld_oth, load_ok, keep, grant;
  logic [ID_WIDTH-1:0]   sel_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]            sel_len;
  assign vld_last      = last_dir ? bus.wr_valid : bus.rd_valid;
  assign vld_oth       = last_dir ? bus.rd_valid : bus.wr_valid;
  assign load_ok       = !bus.cmd_valid || bus.cmd_ready;
  assign keep          = vld_last && (!vld_oth || run_cnt < RL);
  assign grant         = !rst && state == RUN && load_ok && keep;
  assign bus.wr_ready  = grant && last_dir;
  assign bus.rd_ready  = grant && !last_dir;
  assign turn_active   = state == TURN;
  assign sel_id        = last_dir ? bus.wr_id : bus.rd_id;
  assign sel_addr      = last_dir ? bus.wr_addr : bus.rd_addr;
  assign sel_len       = last_dir ? bus.wr_len : bus.rd_len;
  // A turnaround is only committed when the command slot could accept, so backpressure never burns bubbles
  always_comb begin
    state_nx    = state;
    last_dir_nx = last_dir;
    tgt_dir_nx  = tgt_dir;
    run_cnt_nx  = run_cnt;
    turn_cnt_nx = turn_cnt;
    if (grant)
      run_cnt_nx = run_cnt == RL ? run_cnt : run_cnt + 1'b1;
    if (state == RUN && load_ok && !keep && vld_oth) begin
      state_nx    = TURN;
      tgt_dir_nx  = !last_dir;
      turn_cnt_nx = last_dir ? WTR_M1 : RTW_M1;
    end
    if (state == TURN) begin
      turn_cnt_nx = turn_cnt - 1'b1;
      if (turn_cnt == '0) begin
        state_nx    = RUN;
        last_dir_nx = tgt_dir;
        run_cnt_nx  = '0;
        turn_cnt_nx = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      last_dir <= 1'b0;
      tgt_dir  <= 1'b0;
      run_cnt  <= '0;
      turn_cnt <= '0;
    end else begin
      state    <= state_nx;
      last_dir <= last_dir_nx;
      tgt_dir  <= tgt_dir_nx;
      run_cnt  <= run_cnt_nx;
      turn_cnt <= turn_cnt_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cmd_valid <= 1'b0;
      bus.cmd_write <= 1'b0;
      bus.cmd_id    <= '0;
      bus.cmd_addr  <= '0;
      bus.cmd_len   <= '0;
    end else if (grant) begin
      bus.cmd_valid <= 1'b1;
      bus.cmd_write <= last_dir;
      bus.cmd_id    <= sel_id;
      bus.cmd_addr  <= sel_addr;
      bus.cmd_len   <= sel_len;
    end else if (bus.cmd_ready) begin
      bus.cmd_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_openddr_cmd_arbiter.sv
// tb_openddr_cmd_arbiter: directed vector table plus a run-limit sequence for the command arbiter
module tb_openddr_cmd_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic turn_active;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  openddr_cmd_arbiter_if #(.ADDR_WIDTH(40), .ID_WIDTH(12)) bus ();
  openddr_cmd_arbiter #(
    .ADDR_WIDTH(40), .ID_WIDTH(12), .RUN_LIMIT(8), .T_RTW(2), .T_WTR(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .turn_active(turn_active)
  );
  typedef struct {
    logic        rst, wv, rv, cr;
    logic [11:0] wid, rid;
    logic        ew, er, ecv, ecw;
    logic [11:0] eid;
    logic        eta;
  } vec_t;
  vec_t v[26];
  function automatic vec_t mk(input int r, wv, rv, cr, wid, rid, ew, er, ecv, ecw, eid, eta);
    vec_t t;
    t.rst = 1'(r);   t.wv = 1'(wv);    t.rv = 1'(rv);   t.cr = 1'(cr);
    t.wid = 12'(wid); t.rid = 12'(rid);
    t.ew = 1'(ew);   t.er = 1'(er);    t.ecv = 1'(ecv); t.ecw = 1'(ecw);
    t.eid = 12'(eid); t.eta = 1'(eta);
    return t;
  endfunction
  function automatic logic [39:0] wa(input logic [11:0] id);
    return {20'h0, id, 8'h01};
  endfunction
  function automatic logic [39:0] ra(input logic [11:0] id);
    return {20'h0, id, 8'h02};
  endfunction
  task automatic drive(input logic r, wv, rv, cr, input logic [11:0] wid, rid);
    rst           = r;
    bus.wr_valid  = wv;
    bus.wr_id     = wid;
    bus.wr_addr   = wa(wid);
    bus.wr_len    = wid[7:0];
    bus.rd_valid  = rv;
    bus.rd_id     = rid;
    bus.rd_addr   = ra(rid);
    bus.rd_len    = rid[7:0] ^ 8'h80;
    bus.cmd_ready = cr;
  endtask
  initial begin
    string p;
    logic [16:0] got, exp;
    logic [47:0] gpay, epay;
    //           rst wv rv cr wid rid | wr rd cv cw id ta
    v[0]  = mk(1, 1, 1, 1,  0, 0,  0, 0, 0, 0,  0, 0);
    v[1]  = mk(1, 1, 1, 1,  0, 0,  0, 0, 0, 0,  0, 0);
    v[2]  = mk(0, 0, 1, 1,  0, 1,  0, 1, 0, 0,  0, 0);
    v[3]  = mk(0, 0, 1, 1,  0, 2,  0, 1, 1, 0,  1, 0);
    v[4]  = mk(0, 0, 1, 1,  0, 3,  0, 1, 1, 0,  2, 0);
    v[5]  = mk(0, 0, 0, 1,  0, 0,  0, 0, 1, 0,  3, 0);
    v[6]  = mk(0, 0, 0, 1,  0, 0,  0, 0, 0, 0,  3, 0);
    v[7]  = mk(0, 1, 1, 1, 10, 4,  0, 1, 0, 0,  3, 0);
    v[8]  = mk(0, 1, 0, 1, 10, 0,  0, 0, 1, 0,  4, 0);
    v[9]  = mk(0, 1, 0, 1, 10, 0,  0, 0, 0, 0,  4, 1);
    v[10] = mk(0, 1, 0, 1, 10, 0,  0, 0, 0, 0,  4, 1);
    v[11] = mk(0, 1, 0, 1, 10, 0,  1, 0, 0, 0,  4, 0);
    v[12] = mk(0, 0, 0, 1,  0, 0,  0, 0, 1, 1, 10, 0);
    v[13] = mk(0, 0, 0, 1,  0, 0,  0, 0, 0, 1, 10, 0);
    v[14] = mk(0, 1, 0, 1, 11, 0,  1, 0, 0, 1, 10, 0);
    v[15] = mk(0, 0, 1, 0,  0, 5,  0, 0, 1, 1, 11, 0);
    v[16] = mk(0, 0, 1, 0,  0, 5,  0, 0, 1, 1, 11, 0);
    v[17] = mk(0, 0, 1, 0,  0, 5,  0, 0, 1, 1, 11, 0);
    v[18] = mk(0, 0, 1, 0,  0, 5,  0, 0, 1, 1, 11, 0);
    v[19] = mk(0, 0, 1, 0,  0, 5,  0, 0, 1, 1, 11, 0);
    v[20] = mk(0, 0, 1, 1,  0, 5,  0, 0, 1, 1, 11, 0);
    v[21] = mk(0, 0, 1, 1,  0, 5,  0, 0, 0, 1, 11, 1);
    v[22] = mk(1, 0, 1, 1,  0, 5,  0, 0, 0, 1, 11, 1);
    v[23] = mk(0, 0, 1, 1,  0, 6,  0, 1, 0, 0,  0, 0);
    v[24] = mk(0, 0, 0, 1,  0, 0,  0, 0, 1, 0,  6, 0);
    v[25] = mk(0, 0, 0, 1,  0, 0,  0, 0, 0, 0,  6, 0);
    drive(1, 1, 1, 1, 0, 0);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(v[i].rst, v[i].wv, v[i].rv, v[i].cr, v[i].wid, v[i].rid);
      #1;
      got = {bus.wr_ready, bus.rd_ready, bus.cmd_valid, bus.cmd_write, bus.cmd_id, turn_active};
      exp = {v[i].ew, v[i].er, v[i].ecv, v[i].ecw, v[i].eid, v[i].eta};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL vec%0d {wr_rdy,rd_rdy,cv,cw,id,turn} got=%h want=%h", i, got, exp);
      end
      if (v[i].ecv) begin
        gpay = {bus.cmd_addr, bus.cmd_len};
        epay = v[i].ecw ? {wa(v[i].eid), v[i].eid[7:0]} : {ra(v[i].eid), v[i].eid[7:0] ^ 8'h80};
        checks++;
        if (gpay !== epay) begin
          failures++;
          $display("FAIL vec%0d payload {addr,len} got=%h want=%h", i, gpay, epay);
        end
      end
    end
    p = "RRRRRRRR-TTWWWWWWWW-TTTTRRRRRRRR";
    @(negedge clk);
    drive(1, 1, 1, 1, 12'h20, 12'h30);
    @(negedge clk);
    drive(0, 1, 1, 1, 12'h20, 12'h30);
    for (int c = 0; c < p.len(); c++) begin
      byte cur, prv;
      cur = p[c];
      prv = c > 0 ? p[c-1] : 8'h2d;
      #1;
      got = {bus.wr_ready, bus.rd_ready, turn_active, bus.cmd_valid,
             bus.cmd_valid ? bus.cmd_write : 1'b0, 12'h0};
      exp = {cur == "W", cur == "R", cur == "T", prv == "R" || prv == "W", prv == "W", 12'h0};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL runlimit cyc%0d {wr_rdy,rd_rdy,turn,cv,cw} got=%b want=%b",
                 c, got[16:12], exp[16:12]);
      end
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
